dap_multi_chain: RTL

//  Parametrised JTAG debug access port: IEEE 1149.1 TAP state machine, IR, IDCODE, BYPASS,

---
 rtl/dap_pkg.sv | 38 +++
 rtl/dap_tap_fsm.sv | 67 ++++++
 rtl/dap_multi_chain.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/dap_pkg.sv
// dap_pkg: TAP state encodings, fixed opcodes and opcode classification shared by the debug port.
package dap_pkg;

  // Standard 1149.1 four-bit state encoding, also driven out on tap_state.
  typedef enum logic [3:0] {
    TAP_EX2_DR   = 4'h0,
    TAP_EX1_DR   = 4'h1,
    TAP_SHIFT_DR = 4'h2,
    TAP_PAUSE_DR = 4'h3,
    TAP_SEL_IR   = 4'h4,
    TAP_UPD_DR   = 4'h5,
    TAP_CAP_DR   = 4'h6,
    TAP_SEL_DR   = 4'h7,
    TAP_EX2_IR   = 4'h8,
    TAP_EX1_IR   = 4'h9,
    TAP_SHIFT_IR = 4'hA,
    TAP_PAUSE_IR = 4'hB,
    TAP_RTI      = 4'hC,
    TAP_UPD_IR   = 4'hD,
    TAP_CAP_IR   = 4'hE,
    TAP_TLR      = 4'hF
  } tap_state_e;

  localparam logic [31:0]  OPC_IDCODE    = 32'h0000_0001;
  // All ones; users truncate it to their IR width.
  localparam logic [31:0]  OPC_BYPASS    = 32'hFFFF_FFFF;
  localparam int unsigned  DEF_USER_BASE = 32'h10;

  // True when an opcode is IDCODE, BYPASS or one of the user chain opcodes.
  function automatic logic opc_mapped(input logic [31:0] opc, input int unsigned ir_w,
                                      input int unsigned user_base, input int unsigned n_chain);
    logic [31:0] ones;
    ones = OPC_BYPASS >> (32 - ir_w);
    return (opc == ones) || (opc == OPC_IDCODE) ||
           ((opc >= user_base) && (opc < user_base + n_chain));
  endfunction

endpackage

// File: rtl/dap_tap_fsm.sv
// dap_tap_fsm: IEEE 1149.1 TAP controller with one-hot per-state strobes for the datapath.
module dap_tap_fsm
  import dap_pkg::*;
(
  input  logic       i_tck,
  input  logic       i_trst_n,
  input  logic       i_tms,
  output tap_state_e o_state,
  output logic       o_tlr,
  output logic       o_capture_dr,
  output logic       o_shift_dr,
  output logic       o_update_dr,
  output logic       o_capture_ir,
  output logic       o_shift_ir,
  output logic       o_update_ir
);

  tap_state_e r_state;
  tap_state_e w_next;

  // State register; TRST drops straight into Test-Logic-Reset.
  always_ff @(posedge i_tck or negedge i_trst_n) begin
    if (!i_trst_n) r_state <= TAP_TLR;
    else           r_state <= w_next;
  end

  // Next state from TMS and strobes decoded from the registered state.
  always_comb begin
    w_next       = r_state;
    o_tlr        = 1'b0;
    o_capture_dr = 1'b0;
    o_shift_dr   = 1'b0;
    o_update_dr  = 1'b0;
    o_capture_ir = 1'b0;
    o_shift_ir   = 1'b0;
    o_update_ir  = 1'b0;
    case (r_state)
      TAP_TLR:      w_next = i_tms ? TAP_TLR    : TAP_RTI;
      TAP_RTI:      w_next = i_tms ? TAP_SEL_DR : TAP_RTI;
      TAP_SEL_DR:   w_next = i_tms ? TAP_SEL_IR : TAP_CAP_DR;
      TAP_CAP_DR:   w_next = i_tms ? TAP_EX1_DR : TAP_SHIFT_DR;
      TAP_SHIFT_DR: w_next = i_tms ? TAP_EX1_DR : TAP_SHIFT_DR;
      TAP_EX1_DR:   w_next = i_tms ? TAP_UPD_DR : TAP_PAUSE_DR;
      TAP_PAUSE_DR: w_next = i_tms ? TAP_EX2_DR : TAP_PAUSE_DR;
      TAP_EX2_DR:   w_next = i_tms ? TAP_UPD_DR : TAP_SHIFT_DR;
      TAP_UPD_DR:   w_next = i_tms ? TAP_SEL_DR : TAP_RTI;
      TAP_SEL_IR:   w_next = i_tms ? TAP_TLR    : TAP_CAP_IR;
      TAP_CAP_IR:   w_next = i_tms ? TAP_EX1_IR : TAP_SHIFT_IR;
      TAP_SHIFT_IR: w_next = i_tms ? TAP_EX1_IR : TAP_SHIFT_IR;
      TAP_EX1_IR:   w_next = i_tms ? TAP_UPD_IR : TAP_PAUSE_IR;
      TAP_PAUSE_IR: w_next = i_tms ? TAP_EX2_IR : TAP_PAUSE_IR;
      TAP_EX2_IR:   w_next = i_tms ? TAP_UPD_IR : TAP_SHIFT_IR;
      TAP_UPD_IR:   w_next = i_tms ? TAP_SEL_DR : TAP_RTI;
      default:      w_next = TAP_TLR;
    endcase
    o_tlr        = (r_state == TAP_TLR);
    o_capture_dr = (r_state == TAP_CAP_DR);
    o_shift_dr   = (r_state == TAP_SHIFT_DR);
    o_update_dr  = (r_state == TAP_UPD_DR);
    o_capture_ir = (r_state == TAP_CAP_IR);
    o_shift_ir   = (r_state == TAP_SHIFT_IR);
    o_update_ir  = (r_state == TAP_UPD_IR);
  end

  assign o_state = r_state;

endmodule

// File: rtl/dap_multi_chain.sv
// dap_multi_chain: JTAG debug port with IR, IDCODE, BYPASS and N_CHAIN user chains.
// Optional macro DAP_IR_STATUS_EN adds a sticky bad-opcode flag reported in Capture-IR bit 2.
module dap_multi_chain
  import dap_pkg::*;
#(
  parameter int unsigned IR_W      = 8,
  parameter int unsigned N_CHAIN   = 4,
  parameter logic [31:0] IDCODE    = 32'h1234_5678,
  parameter int unsigned USER_BASE = DEF_USER_BASE
) (
  input  logic               TCK,
  input  logic               TRST,
  input  logic               TMS,
  input  logic               TDI,
  output logic               TDO,
  output logic               TDO_OE,
  output logic [3:0]         tap_state,
  output logic               chain_tdi,
  input  logic [N_CHAIN-1:0] chain_tdo,
  output logic [N_CHAIN-1:0] chain_capture,
  output logic [N_CHAIN-1:0] chain_shift,
  output logic [N_CHAIN-1:0] chain_update,
  output logic [N_CHAIN-1:0] chain_sel
);

  tap_state_e         w_state;
  logic               w_tlr;
  logic               w_capture_dr;
  logic               w_shift_dr;
  logic               w_update_dr;
  logic               w_capture_ir;
  logic               w_shift_ir;
  logic               w_update_ir;
  logic [IR_W-1:0]    r_ir_shift;
  logic [IR_W-1:0]    r_ir_upd;
  logic [IR_W-1:0]    w_ir_capture;
  logic [31:0]        w_opc;
  logic [N_CHAIN-1:0] w_sel;
  logic               w_is_idcode;
  logic               w_is_user;
  logic               w_bad_op;
  logic [31:0]        r_idcode_dr;
  logic               r_bypass;
  logic               w_dr_lsb;

  dap_tap_fsm u_fsm (
    .i_tck        (TCK),
    .i_trst_n     (TRST),
    .i_tms        (TMS),
    .o_state      (w_state),
    .o_tlr        (w_tlr),
    .o_capture_dr (w_capture_dr),
    .o_shift_dr   (w_shift_dr),
    .o_update_dr  (w_update_dr),
    .o_capture_ir (w_capture_ir),
    .o_shift_ir   (w_shift_ir),
    .o_update_ir  (w_update_ir)
  );

`ifdef DAP_IR_STATUS_EN
  logic r_bad_op;

  // Sticky flag: set when an unmapped opcode is loaded, cleared once it has been captured.
  always_ff @(posedge TCK or negedge TRST) begin
    if (!TRST)             r_bad_op <= 1'b0;
    else if (w_capture_ir) r_bad_op <= 1'b0;
    else if (w_update_ir && !opc_mapped(32'(r_ir_shift), IR_W, USER_BASE, N_CHAIN))
                           r_bad_op <= 1'b1;
  end

  assign w_bad_op = r_bad_op;
`else
  assign w_bad_op = 1'b0;
`endif

  // Capture-IR pattern: fixed 01 in the low bits plus the status flag in bit 2.
  always_comb begin
    w_ir_capture      = '0;
    w_ir_capture[2]   = w_bad_op;
    w_ir_capture[1:0] = 2'b01;
  end

  // IR shift register: loads the capture pattern, then shifts right with TDI into the MSB.
  always_ff @(posedge TCK or negedge TRST) begin
    if (!TRST)             r_ir_shift <= '0;
    else if (w_capture_ir) r_ir_shift <= w_ir_capture;
    else if (w_shift_ir)   r_ir_shift <= {TDI, r_ir_shift[IR_W-1:1]};
  end

  // Active instruction: IDCODE after any reset, new opcode on the edge leaving Update-IR.
  always_ff @(posedge TCK or negedge TRST) begin
    if (!TRST)            r_ir_upd <= OPC_IDCODE[IR_W-1:0];
    else if (w_tlr)       r_ir_upd <= OPC_IDCODE[IR_W-1:0];
    else if (w_update_ir) r_ir_upd <= r_ir_shift;
  end

  // Instruction decode; anything not IDCODE or a user chain falls back to BYPASS.
  always_comb begin
    w_opc       = 32'(r_ir_upd);
    w_sel       = '0;
    w_is_idcode = 1'b0;
    w_is_user   = 1'b0;
    if (r_ir_upd != OPC_BYPASS[IR_W-1:0]) begin
      if (w_opc == OPC_IDCODE) begin
        w_is_idcode = 1'b1;
      end else begin
        for (int unsigned k = 0; k < N_CHAIN; k++) begin
          if (w_opc == USER_BASE + k) begin
            w_sel[k]  = 1'b1;
            w_is_user = 1'b1;
          end
        end
      end
    end
  end

  // Internal data registers: 32-bit IDCODE shifter and the single BYPASS bit.
  always_ff @(posedge TCK or negedge TRST) begin
    if (!TRST) begin
      r_idcode_dr <= '0;
      r_bypass    <= 1'b0;
    end else begin
      if (w_is_idcode && w_capture_dr)    r_idcode_dr <= IDCODE;
      else if (w_is_idcode && w_shift_dr) r_idcode_dr <= {TDI, r_idcode_dr[31:1]};
      if (!w_is_idcode && !w_is_user) begin
        if (w_capture_dr)    r_bypass <= 1'b0;
        else if (w_shift_dr) r_bypass <= TDI;
      end
    end
  end

  // Serial source for Shift-DR: the selected internal register or the selected chain.
  always_comb begin
    w_dr_lsb = r_bypass;
    if (w_is_idcode)    w_dr_lsb = r_idcode_dr[0];
    else if (w_is_user) w_dr_lsb = |(chain_tdo & w_sel);
  end

  // TDO and its enable change on the falling edge so the far end samples them on the rise.
  always_ff @(negedge TCK or negedge TRST) begin
    if (!TRST) begin
      TDO    <= 1'b0;
      TDO_OE <= 1'b0;
    end else if (w_shift_ir) begin
      TDO    <= r_ir_shift[0];
      TDO_OE <= 1'b1;
    end else if (w_shift_dr) begin
      TDO    <= w_dr_lsb;
      TDO_OE <= 1'b1;
    end else begin
      TDO    <= 1'b0;
      TDO_OE <= 1'b0;
    end
  end

  assign tap_state     = w_state;
  assign chain_tdi     = TDI;
  assign chain_sel     = w_sel;
  assign chain_capture = w_capture_dr ? w_sel : '0;
  assign chain_shift   = w_shift_dr   ? w_sel : '0;
  assign chain_update  = w_update_dr  ? w_sel : '0;

endmodule
